fetch2: RTL
===========

Name: fetch2

Overview:
- Second fetch stage, directly downstream of the PC/request stage (fetch1).
- Tracks instruction-bus requests accepted by fetch1 in order and pairs each returning data word with its PC.
- Buffers {pc, instr} pairs in an instruction queue that decode drains.
- Generates queue_full back to fetch1 using credits, so every outstanding response always has a queue slot.
- On flush, discards the queue and every in-flight response from the old path.

Parameters:
- IQ_DEPTH, 8, instruction queue entries; power of 2, ≥2.
- PEND_DEPTH, 4, maximum accepted-but-unanswered requests; power of 2.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- req_pc  input  32  PC of the request presented this cycle (fetch1 cur_PC_nxt)
- req_fire  input  1  request accepted this cycle (valid & addr_ok & ~queue_full & ~fetch_halt)
- resp_data_ok  input  1  instruction bus returns a word this cycle
- resp_data  input  32  returned instruction word
- flush  input  1  redirect (branch mispredict, eret, cp0_flush), ORed upstream
- queue_full  output  1  stall fetch1 PC advance
- out_valid  output  1  head entry valid
- out_pc  output  32  head PC
- out_instr  output  32  head instruction
- out_ready  input  1  decode consumes head when out_valid & out_ready

Behaviour:
- Reset (resetn=0 at posedge): both FIFOs empty, discard_cnt=0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, queue_full=0.
  - Reset has priority over every other input, including in the middle of outstanding requests.
- Pending FIFO:
  - req_fire pushes req_pc.
  - A live response (resp_data_ok & discard_cnt==0) pops the head PC.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Discarding:
  - While discard_cnt>0, resp_data_ok decrements discard_cnt and its data is dropped.
  - A live response pushes {popped PC, resp_data} into the instruction queue.
- Instruction queue:
  - Circular buffer with rd/wr pointers and a count of width $clog2(IQ_DEPTH)+1; pointers wrap modulo IQ_DEPTH.
  - Simultaneous push and pop is legal at any fill level, including full (pop frees the slot).
- Output: registered-free read of the head entry.
  - out_valid = iq_count!=0.
  - 1-cycle minimum latency: data_ok in cycle N → out_valid in cycle N+1.
- Credit rule:
  - queue_full = (iq_count + pend_cnt + discard_cnt >= IQ_DEPTH) | (pend_cnt + discard_cnt == PEND_DEPTH).
  - Combinational from registers only; no dependence on same-cycle inputs.
- Flush (highest priority after reset):
  - Next cycle: iq_count=0, pend_cnt=0.
  - discard_cnt <= discard_cnt + pend_cnt + req_fire − resp_data_ok.
  - A request firing in the flush cycle carries an old-path PC and is discarded.
  - A decode pop in the flush cycle is ignored.
- Protocol error: resp_data_ok with pend_cnt==0 and discard_cnt==0 is ignored, with no state change. A simulation assertion flags it.
- Assertions:
  - No push when full.
  - No pend overflow.
  - discard_cnt never underflows.

Optional Feature:
- Macro: FETCH2_BYPASS_EN.
- Defined: when iq_count==0 and a live response arrives, out_valid=1 in the same cycle, with out_pc/out_instr taken directly from the popped PC and resp_data.
  - If out_ready=1, the entry is consumed and not written to the queue.
  - Otherwise it is written normally.
  - Latency drops to 0 cycles.
- Undefined: always 1-cycle latency through the queue; no combinational path from resp_* to out_*.

Decomposition:
- addr_t and word_t come from the existing common header.
- New shared package items:
  - fetch_entry_t struct {addr_t pc; word_t instr;}.
  - Default IQ_DEPTH/PEND_DEPTH constants.
- One natural sub-module: fetch_fifo, a generic parameterised synchronous FIFO (DEPTH, type T) with push/pop/clear/count.
  - Instantiated twice: pending PCs and instruction queue.
- Credit, discard and flush logic stays in fetch2.

Test Plan:
- Basic: fire 0xbfc00000, 0xbfc00004; data_ok with 0x24020001, 0x24030002 → decode sees (0xbfc00000,0x24020001) then (0xbfc00004,0x24030002) in order.
- Backpressure: out_ready=0, IQ_DEPTH=8, stream requests until iq_count+pend_cnt=8 → queue_full=1; no entry lost; one pop → queue_full deasserts next cycle.
- Flush with 3 outstanding plus req_fire in the same cycle → discard_cnt=4; next 4 data_ok dropped; 5th response, paired with new PC 0x80000180, is delivered.
- Flush coincident with resp_data_ok and out_ready, 2 pending → discard_cnt=1, queue empty, out_valid=0 next cycle.
- Wrap-around: 20 push/pop pairs at full throughput → pointers wrap, PCs sequential 0xbfc00000+4k, no duplicates or drops.
- Reset mid-stream with 2 pending, 5 queued → all counts 0, queue_full=0, out_valid=0; a stale data_ok after reset triggers the protocol assertion only.

Source files
------------

// File: rtl/fetch2_pkg.sv
// fetch2_pkg: shared types and default sizes for the second fetch stage.
//   addr_t / word_t  : 32-bit address and instruction word (same shape as
//                      the common header types)
//   fetch_entry_t    : {pc, instr} pair held in the instruction queue
//   *_DEFAULT        : default queue depths for fetch2
package fetch2_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam int IQ_DEPTH_DEFAULT   = 8;
    localparam int PEND_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous circular FIFO.
//   clk, resetn   : clock, synchronous active-low reset
//   clear         : drop all contents (pointers and count return to 0)
//   push/push_data: write one entry at the tail
//   pop           : release the head entry
//   head          : current head entry (combinational read)
//   count         : number of stored entries, 0..DEPTH
//   empty / full  : count==0 / count==DEPTH
// Push and pop together are legal at any fill level; when full, the pop
// frees the slot the push lands in. DEPTH must be a power of 2 so the
// pointers wrap by plain overflow.
module fetch_fifo
    import fetch2_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; readers qualify head with a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    always @(posedge clk) begin
        if (resetn && !clear) begin
            assert (!(push && full && !pop))
                else $error("fetch_fifo: push while full");
            assert (!(pop && empty))
                else $error("fetch_fifo: pop while empty");
        end
    end

endmodule

// File: rtl/fetch2.sv
// fetch2: second fetch stage. Pairs each instruction-bus response with the
// PC of the request that produced it and queues {pc, instr} for decode.
//   clk, resetn          : clock, synchronous active-low reset
//   req_pc, req_fire     : request accepted by fetch1 this cycle and its PC
//   resp_data_ok/_data   : instruction word returned by the bus
//   flush                : redirect; old-path queue and responses discarded
//   queue_full           : credit stall back to fetch1
//   out_valid/_pc/_instr : head of the instruction queue
//   out_ready            : decode consumes the head
// Build option FETCH2_BYPASS_EN: a live response arriving at an empty queue
// is presented on out_* in the same cycle (and skips the queue if taken).
// Without it, out_* depend only on registers.
module fetch2
    import fetch2_pkg::*;
#(
    parameter int IQ_DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int PEND_DEPTH = PEND_DEPTH_DEFAULT
) (
    input  logic  clk,
    input  logic  resetn,
    input  addr_t req_pc,
    input  logic  req_fire,
    input  logic  resp_data_ok,
    input  word_t resp_data,
    input  logic  flush,
    output logic  queue_full,
    output logic  out_valid,
    output addr_t out_pc,
    output word_t out_instr,
    input  logic  out_ready
);

    localparam int IQW = $clog2(IQ_DEPTH) + 1;
    localparam int PDW = $clog2(PEND_DEPTH) + 1;
    localparam int SW  = $clog2(IQ_DEPTH + 2*PEND_DEPTH) + 1;

    logic [IQW-1:0] iq_count;
    logic [PDW-1:0] pend_cnt;
    logic [PDW-1:0] discard_cnt;
    logic [PDW-1:0] discard_nxt;
    logic [SW-1:0]  flush_sum;
    logic [SW-1:0]  pend_used;
    logic [SW-1:0]  credit_used;

    addr_t          pend_head;
    fetch_entry_t   iq_head;
    fetch_entry_t   iq_wdata;
    logic           pend_empty, pend_full;
    logic           iq_empty, iq_full;
    logic           resp_live, resp_drop, resp_taken;
    logic           pend_push, pend_pop;
    logic           iq_push, iq_pop;
    logic           bypass_take;

    // A response belongs to the old path while discard_cnt is non-zero.
    // One with nothing outstanding at all is a bus protocol error and is
    // treated as if it never happened.
    assign resp_drop  = resp_data_ok & (discard_cnt != '0);
    assign resp_live  = resp_data_ok & (discard_cnt == '0) & ~pend_empty;
    assign resp_taken = resp_drop | resp_live;

    assign pend_push  = req_fire & ~flush;
    assign pend_pop   = resp_live & ~flush;
    assign iq_wdata   = '{pc: pend_head, instr: resp_data};

    fetch_fifo #(.DEPTH(PEND_DEPTH), .T(addr_t)) u_pend (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (pend_push),
        .push_data (req_pc),
        .pop       (pend_pop),
        .head      (pend_head),
        .count     (pend_cnt),
        .empty     (pend_empty),
        .full      (pend_full)
    );

`ifdef FETCH2_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = resp_live & iq_empty & ~flush;
    assign bypass_take = bypass_hit & out_ready;
    assign out_valid   = ~iq_empty | bypass_hit;
    assign out_pc      = ~iq_empty ? iq_head.pc    : (bypass_hit ? pend_head : '0);
    assign out_instr   = ~iq_empty ? iq_head.instr : (bypass_hit ? resp_data : '0);
`else
    assign bypass_take = 1'b0;
    assign out_valid   = ~iq_empty;
    // Zero while empty so stale storage never shows on the outputs.
    assign out_pc      = out_valid ? iq_head.pc    : '0;
    assign out_instr   = out_valid ? iq_head.instr : '0;
`endif

    assign iq_push = resp_live & ~flush & ~bypass_take;
    assign iq_pop  = out_ready & ~iq_empty & ~flush;

    fetch_fifo #(.DEPTH(IQ_DEPTH), .T(fetch_entry_t)) u_iq (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (iq_push),
        .push_data (iq_wdata),
        .pop       (iq_pop),
        .head      (iq_head),
        .count     (iq_count),
        .empty     (iq_empty),
        .full      (iq_full)
    );

    // On flush every pending request, plus one firing in the same cycle,
    // becomes a response to throw away; a response taken in that cycle
    // already accounts for one of them.
    always_comb begin
        flush_sum   = SW'(discard_cnt) + SW'(pend_cnt) + SW'(req_fire);
        discard_nxt = discard_cnt;
        if (flush) begin
            discard_nxt = PDW'(flush_sum - SW'(resp_taken));
        end else if (resp_drop) begin
            discard_nxt = discard_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_nxt;
        end
    end

    // Every request in flight (live or to be discarded) holds a queue slot,
    // so a response can always be written without a stall path to the bus.
    assign pend_used   = SW'(pend_cnt) + SW'(discard_cnt);
    assign credit_used = SW'(iq_count) + pend_used;
    assign queue_full  = (credit_used >= SW'(IQ_DEPTH)) |
                         (pend_used == SW'(PEND_DEPTH));

    always @(posedge clk) begin
        if (resetn) begin
            assert (!(resp_data_ok && pend_empty && discard_cnt == '0))
                else $warning("fetch2: stray response with nothing outstanding ignored");
            assert (!(iq_push && iq_full && !iq_pop))
                else $error("fetch2: instruction queue push while full");
            assert (!(pend_push && pend_full))
                else $error("fetch2: pending PC queue overflow");
            assert (!(flush && (flush_sum < SW'(resp_taken))))
                else $error("fetch2: discard count underflow");
            assert (!(flush && (flush_sum - SW'(resp_taken) > SW'(PEND_DEPTH))))
                else $error("fetch2: discard count exceeds pending depth");
        end
    end

endmodule
